// File: rtl/tdm_demux4_pkg.sv
// Shared TDM definitions: frame-alignment states and slot codes.
// The slot codes match the select codes of the transmit-side 4:1 mux.
package tdm_pkg;

    typedef enum logic {
        HUNT,
        LOCK
    } state_t;

    localparam logic [1:0] SLOT_A = 2'b00;
    localparam logic [1:0] SLOT_B = 2'b01;
    localparam logic [1:0] SLOT_C = 2'b10;
    localparam logic [1:0] SLOT_D = 2'b11;

endpackage

// File: rtl/tdm_demux4_if.sv
// Bus bundle for the 4-way TDM demultiplexer: interleaved input stream
// plus the rebuilt, frame-aligned channel outputs and status flags.
interface tdm_demux4_if #(
    parameter int WIDTH = 1
) ();

    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             sync;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic [1:0]       slot;

    // Stream source / channel consumer side.
    modport master (
        output din, din_valid, sync,
        input  a, b, c, d, frame_valid, locked, sync_err, slot
    );

    // Demultiplexer side.
    modport slave (
        input  din, din_valid, sync,
        output a, b, c, d, frame_valid, locked, sync_err, slot
    );

endinterface

// File: rtl/tdm_demux4.sv
// Four-way TDM demultiplexer. Collects slots 0..2 into shadow registers and
// updates all four channel outputs together on the edge that accepts slot 3.
// A sync marker acquires frame alignment; misplaced or missing syncs pulse
// sync_err.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int WIDTH      = 1,
    parameter bit CHECK_SYNC = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    tdm_demux4_if.slave  bus
);

    state_t           state_q, state_d;
    logic [1:0]       slot_q, slot_d;
    logic [WIDTH-1:0] shadow_q [3];
    logic [WIDTH-1:0] shadow_d [3];
    logic [WIDTH-1:0] chan_q   [4];
    logic [WIDTH-1:0] chan_d   [4];
    logic             frame_valid_q, frame_valid_d;
    logic             sync_err_q, sync_err_d;

    // Next-state, slot counter and frame assembly; pulses default low.
    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        shadow_d      = shadow_q;
        chan_d        = chan_q;
        frame_valid_d = 1'b0;
        sync_err_d    = 1'b0;

        if (bus.din_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (bus.sync) begin
                        shadow_d[0] = bus.din;
                        slot_d      = SLOT_B;
                        state_d     = LOCK;
                    end
                end
                LOCK: begin
                    if (bus.sync && slot_q != SLOT_A) begin
                        // Early sync: drop the partial frame, restart on this sample.
                        sync_err_d  = 1'b1;
                        shadow_d[0] = bus.din;
                        slot_d      = SLOT_B;
                    end else begin
                        case (slot_q)
                            SLOT_A: begin
                                if (!bus.sync && CHECK_SYNC) begin
                                    sync_err_d = 1'b1;
                                    state_d    = HUNT;
                                    slot_d     = SLOT_A;
                                end else begin
                                    shadow_d[0] = bus.din;
                                    slot_d      = slot_q + 2'd1;
                                end
                            end
                            SLOT_B: begin
                                shadow_d[1] = bus.din;
                                slot_d      = slot_q + 2'd1;
                            end
                            SLOT_C: begin
                                shadow_d[2] = bus.din;
                                slot_d      = slot_q + 2'd1;
                            end
                            default: begin
                                chan_d[0]     = shadow_q[0];
                                chan_d[1]     = shadow_q[1];
                                chan_d[2]     = shadow_q[2];
                                chan_d[3]     = bus.din;
                                frame_valid_d = 1'b1;
                                slot_d        = slot_q + 2'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // State, shadow and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= HUNT;
            slot_q        <= SLOT_A;
            shadow_q      <= '{default: '0};
            chan_q        <= '{default: '0};
            frame_valid_q <= 1'b0;
            sync_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            shadow_q      <= shadow_d;
            chan_q        <= chan_d;
            frame_valid_q <= frame_valid_d;
            sync_err_q    <= sync_err_d;
        end
    end

    assign bus.a           = chan_q[0];
    assign bus.b           = chan_q[1];
    assign bus.c           = chan_q[2];
    assign bus.d           = chan_q[3];
    assign bus.frame_valid = frame_valid_q;
    assign bus.sync_err    = sync_err_q;
    assign bus.locked      = (state_q == LOCK);
    assign bus.slot        = slot_q;

endmodule
